dm_access_master: RTL
=====================

// Module: dm_access_master
// PURPOSE
//   Initiator side of the data-memory port: MEM-stage load/store unit that accepts one
//   request from the pipeline, checks alignment and address range, drives the data
//   memory (we/type/sign/addr/wd/pc), captures load data and returns a response.
//   Sits between the MEM-stage pipeline register and the word-organised data memory.
// PARAMETERS
//   MAX_WORD_LEN  12           log2 of data-memory depth in words
//   DM_BASE       32'h0000     first legal byte address
//   DM_SIZE       32'h3000     legal byte span; legal iff DM_BASE <= addr < DM_BASE+DM_SIZE
// PORTS
//   clk           in   1   clock, rising edge
//   reset         in   1   synchronous, active-high
//   flush         in   1   drop request in IDLE accept / pending response
//   req_valid     in   1   request present
//   req_ready     out  1   block can accept (state==IDLE)
//   req_we        in   1   1=store, 0=load
//   req_type      in   2   00 word, 01 half, 10 byte, 11 reserved (same codes as dm_type)
//   req_sign      in   1   1=sign-extend loads
//   req_addr      in   32  byte address
//   req_wdata     in   32  store data, low bits used for half/byte
//   req_pc        in   32  PC of instruction
//   dm_we         out  1   memory write enable
//   dm_type       out  2   memory access width
//   dm_sign       out  1   memory sign select
//   dm_addr       out  32  memory byte address
//   dm_wd         out  32  memory write data
//   dm_pc         out  32  PC forwarded for write trace
//   dm_rd         in   32  memory read data (combinational, already extended)
//   resp_valid    out  1   response present
//   resp_ready    in   1   consumer takes response
//   resp_rdata    out  32  load result (0 for stores/exceptions)
//   resp_exc      out  1   exception flag
//   resp_exccode  out  5   4=AdEL (load), 5=AdES (store), 0 otherwise
//   resp_badvaddr out  32  faulting address (0 if no exception)
//   resp_pc       out  32  PC of responding request
// BEHAVIOUR
//   - FSM states IDLE, ACCESS, RESP. Reset: IDLE; every output register 0; resp_valid=0,
//     req_ready=1, dm_we=0, dm_type=0, dm_sign=0, dm_addr=0, dm_wd=0, dm_pc=0.
//   - IDLE: req_ready=1. On req_valid && !flush all req_* latched. Fault if addr out of range,
//     word with addr[1:0]!=0, half with addr[0]!=0, or type 11. Fault -> RESP with
//     resp_exc=1, exccode 5 if store else 4, badvaddr=addr; memory never touched.
//     No fault -> ACCESS. req_valid with flush in IDLE: ignored, stay IDLE.
//   - ACCESS (exactly 1 cycle): dm_* driven from latched request; dm_we=we_q && !reset.
//     Store commits at the closing edge. Load: dm_rd captured into resp_rdata at that edge.
//     flush in ACCESS ignored (access already committed). Next state RESP.
//   - RESP: resp_valid=1, outputs held stable until resp_ready; on resp_ready -> IDLE.
//     flush in RESP: response dropped, -> IDLE, resp_valid low next cycle.
//     resp_ready and flush together: flush wins (treated as dropped).
//   - Outside ACCESS: dm_we=0, dm_addr/type/sign/wd/pc hold last latched values.
//   - Latency: accept edge N -> ACCESS cycle N+1 -> resp_valid at N+2; fault -> resp_valid at N+1.
//     Max throughput 1 request / 3 cycles; req_ready low in ACCESS and RESP.
//   - Range check in 33-bit arithmetic: DM_BASE+DM_SIZE does not wrap.
//   - reset in any state: next edge IDLE, all cleared; dm_we gated by reset in the same cycle.
// TESTING
//   - sw addr 0x10 wdata 0xDEADBEEF -> dm_we=1 one cycle at N+1, resp_valid N+2, exc=0.
//   - lb sign addr 0x13 after word 0x80xxxxxx stored -> resp_rdata 0xFFFFFF80; lbu -> 0x00000080.
//   - lw addr 0x6 -> no dm_we, resp_exc=1 exccode 4 badvaddr 0x6 at N+1; sh 0x3001 -> exccode 5.
//   - sw addr 0x3000 (DM_SIZE boundary) -> AdES; lw 0x2FFC -> legal load, exc=0.
//   - resp_ready held 0 for 5 cycles -> resp_* stable, req_ready=0; flush in RESP -> IDLE, no response.
//   - reset asserted during ACCESS of a store -> dm_we=0 that cycle, IDLE next, resp_valid=0.

Source files
------------

// File: rtl/dm_access_master.sv
// dm_access_master - MEM-stage load/store initiator: alignment/range check, one-cycle
// data-memory access, registered response with exception reporting.
module dm_access_master #(
  parameter int unsigned MAX_WORD_LEN = 12,
  parameter logic [31:0] DM_BASE      = 32'h0000,
  parameter logic [31:0] DM_SIZE      = 32'h3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_type,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        dm_we,
  output logic [1:0]  dm_type,
  output logic        dm_sign,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exccode,
  output logic [31:0] resp_badvaddr,
  output logic [31:0] resp_pc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  type_q, type_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_exc_q, resp_exc_d;
  logic [4:0]  resp_exccode_q, resp_exccode_d;
  logic [31:0] resp_badvaddr_q, resp_badvaddr_d;
  logic [31:0] resp_pc_q, resp_pc_d;

  // Range check is done on 33 bits so DM_BASE+DM_SIZE can never wrap to a small value.
  logic [32:0] addr_ext, base_ext, limit_ext, word_off, depth_words;
  logic        in_range, misaligned, fault;

  always_comb begin
    addr_ext    = {1'b0, req_addr};
    base_ext    = {1'b0, DM_BASE};
    limit_ext   = base_ext + {1'b0, DM_SIZE};
    word_off    = (addr_ext - base_ext) >> 2;
    depth_words = 33'd1 << MAX_WORD_LEN;
    in_range    = (addr_ext >= base_ext) && (addr_ext < limit_ext) && (word_off < depth_words);
    misaligned  = ((req_type == 2'b00) && (req_addr[1:0] != 2'b00)) ||
                  ((req_type == 2'b01) && req_addr[0]) ||
                  (req_type == 2'b11);
    fault       = !in_range || misaligned;
  end

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    type_d          = type_q;
    sign_d          = sign_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    pc_d            = pc_q;
    resp_rdata_d    = resp_rdata_q;
    resp_exc_d      = resp_exc_q;
    resp_exccode_d  = resp_exccode_q;
    resp_badvaddr_d = resp_badvaddr_q;
    resp_pc_d       = resp_pc_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          we_d         = req_we;
          type_d       = req_type;
          sign_d       = req_sign;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          pc_d         = req_pc;
          resp_pc_d    = req_pc;
          resp_rdata_d = 32'd0;
          if (fault) begin
            resp_exc_d      = 1'b1;
            resp_exccode_d  = req_we ? EXC_ADES : EXC_ADEL;
            resp_badvaddr_d = req_addr;
            state_d         = RESP;
          end else begin
            resp_exc_d      = 1'b0;
            resp_exccode_d  = 5'd0;
            resp_badvaddr_d = 32'd0;
            state_d         = ACCESS;
          end
        end
      end
      ACCESS: begin
        // The access is committed this cycle, so flush is deliberately not looked at.
        resp_rdata_d = we_q ? 32'd0 : dm_rd;
        state_d      = RESP;
      end
      RESP: begin
        if (flush || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      type_q          <= 2'b00;
      sign_q          <= 1'b0;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      pc_q            <= 32'd0;
      resp_rdata_q    <= 32'd0;
      resp_exc_q      <= 1'b0;
      resp_exccode_q  <= 5'd0;
      resp_badvaddr_q <= 32'd0;
      resp_pc_q       <= 32'd0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      type_q          <= type_d;
      sign_q          <= sign_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      pc_q            <= pc_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_exc_q      <= resp_exc_d;
      resp_exccode_q  <= resp_exccode_d;
      resp_badvaddr_q <= resp_badvaddr_d;
      resp_pc_q       <= resp_pc_d;
    end
  end

  // Write enable is gated by reset combinationally so a reset during ACCESS blocks the store.
  assign dm_we         = (state_q == ACCESS) && we_q && !reset;
  assign dm_type       = type_q;
  assign dm_sign       = sign_q;
  assign dm_addr       = addr_q;
  assign dm_wd         = wdata_q;
  assign dm_pc         = pc_q;
  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_exc      = resp_exc_q;
  assign resp_exccode  = resp_exccode_q;
  assign resp_badvaddr = resp_badvaddr_q;
  assign resp_pc       = resp_pc_q;

endmodule
